// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB initiator for the bridge.
// Takes single read/write requests on a valid/ready port, decodes the address
// into one of three peripheral slots, runs SETUP->ACCESS with wait-state and
// timeout handling, and returns exactly one response per accepted request.
module apb_master_fsm #(
  parameter int unsigned TIMEOUT   = 16,            // 0 disables, legal 0..255
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SLOT_BITS = 26
) (
  input  logic        hclk,
  input  logic        hresetn,
  // request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // response port
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // APB initiator bundle
  output logic [2:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  localparam int unsigned NUM_SLOTS   = 3;
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  psel_reg, psel_next;
  logic        penable_reg, penable_next;
  logic        pwrite_reg, pwrite_next;
  logic [31:0] paddr_reg, paddr_next;
  logic [31:0] pwdata_reg, pwdata_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [7:0]  wait_cnt_inc;

  // ---------------------------------------------------------------------------
  // Address decode: slot index is the offset from the window base in units of
  // one slot. Anything below the base or past the last slot is a decode error.
  // ---------------------------------------------------------------------------
  logic [31:0] addr_offset;
  logic [31:0] slot_idx;
  logic        below_base;
  logic [2:0]  dec_sel;
  logic        dec_err;

  assign below_base  = (req_addr < BASE_ADDR);
  assign addr_offset = req_addr - BASE_ADDR;
  assign slot_idx    = addr_offset >> SLOT_BITS;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_dec
      assign dec_sel[gi] = !below_base && (slot_idx == 32'(gi));
    end
  endgenerate

  // No select bit set means the address fell outside every slot.
  assign dec_err = ~|dec_sel;

  // The only combinational output: ready whenever no transfer is in flight.
  assign req_ready = (state_reg == IDLE);

  // Saturation is never reached: the abort fires before the counter wraps.
  assign wait_cnt_inc = wait_cnt_reg + 8'd1;

  // Next-state and next-output logic for the SETUP/ACCESS sequence.
  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    wait_cnt_next  = wait_cnt_reg;
    // The response is a one-cycle pulse; its payload is zero when not valid.
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = 32'd0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (dec_err) begin
            // Unmapped address: answer immediately, leave the APB bus idle
            // so paddr/pwrite/pwdata keep their previous values.
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else begin
            paddr_next  = req_addr;
            pwrite_next = req_write;
            pwdata_next = req_write ? req_wdata : 32'd0;
            psel_next   = dec_sel;
            state_next  = SETUP;
          end
        end
      end

      SETUP: begin
        penable_next  = 1'b1;
        wait_cnt_next = 8'd0;
        state_next    = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // Completion takes priority over a timeout landing on the same edge.
          psel_next      = 3'b000;
          penable_next   = 1'b0;
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? 32'd0 : prdata;
        end else if (TIMEOUT_EN) begin
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc == TIMEOUT_CNT) begin
            psel_next      = 3'b000;
            penable_next   = 1'b0;
            state_next     = IDLE;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet bus.
        psel_next    = 3'b000;
        penable_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  // State and registered-output update; reset aborts any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg     <= IDLE;
      psel_reg      <= 3'b000;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= 32'd0;
      pwdata_reg    <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      wait_cnt_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      wait_cnt_reg  <= wait_cnt_next;
    end
  end

  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: directed and randomized requests against apb_master_fsm,
// checked cycle by cycle against a transaction-level expectation.
module tb_apb_master_fsm;

  localparam int unsigned TO        = 4;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] SLOT_SIZE = 32'h0400_0000;  // 64 MB

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'd0;
  logic        pready = 1'b0;

  apb_master_fsm #(
    .TIMEOUT  (TO),
    .BASE_ADDR(BASE),
    .SLOT_BITS(26)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side memory of the bus: last APB transfer's attributes.
  logic [31:0] last_paddr  = 32'd0;
  logic        last_pwrite = 1'b0;
  logic [31:0] last_pwdata = 32'd0;
  int          gap_exp = -1;
  int          last_setup_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Slot table: three 64 MB windows starting at BASE.
  function automatic logic [2:0] model_sel(input logic [31:0] a);
    int unsigned idx;
    if (a < BASE) return 3'b000;
    idx = (a - BASE) / SLOT_SIZE;
    case (idx)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // One request: present it, follow the bus cycle by cycle, check the response.
  // hold=1 leaves req_valid high so the next call is accepted back-to-back.
  task automatic run_req(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int nwaits, input bit hold);
    logic [2:0]  sel;
    bit          err;
    int          acc;
    logic [31:0] rd_exp;
    sel = model_sel(addr);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    chk("req_ready_idle", req_ready, 1);
    @(posedge hclk); @(negedge hclk);
    if (sel == 3'b000) begin
      if (!hold) req_valid = 1'b0;
      chk("dec_rsp_valid", rsp_valid, 1);
      chk("dec_rsp_err", rsp_err, 1);
      chk("dec_rsp_rdata", rsp_rdata, 0);
      chk("dec_psel", psel, 0);
      chk("dec_penable", penable, 0);
      chk("dec_paddr_hold", paddr, last_paddr);
      chk("dec_req_ready", req_ready, 1);
      $display("txn dec_err addr=%08h wr=%0d", addr, wr);
      gap_exp = -1;
    end else begin
      // Busy: scramble request fields, they must be ignored.
      req_valid = hold;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
      if (gap_exp >= 0) chk("psel_gap", cyc - last_setup_cyc, gap_exp);
      last_setup_cyc = cyc;
      chk("setup_psel", psel, sel);
      chk("setup_penable", penable, 0);
      chk("setup_pwrite", pwrite, wr);
      chk("setup_paddr", paddr, addr);
      chk("setup_pwdata", pwdata, wr ? wd : 32'd0);
      chk("setup_req_ready", req_ready, 0);
      chk("setup_rsp_valid", rsp_valid, 0);
      last_paddr  = addr;
      last_pwrite = wr;
      last_pwdata = wr ? wd : 32'd0;
      err    = (nwaits >= int'(TO));
      acc    = err ? int'(TO) : nwaits + 1;
      rd_exp = 32'd0;
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;
      @(posedge hclk); @(negedge hclk);
      for (int k = 0; k < acc; k++) begin
        chk("acc_psel", psel, sel);
        chk("acc_penable", penable, 1);
        chk("acc_paddr", paddr, addr);
        chk("acc_pwrite", pwrite, wr);
        chk("acc_pwdata", pwdata, wr ? wd : 32'd0);
        chk("acc_req_ready", req_ready, 0);
        chk("acc_rsp_valid", rsp_valid, 0);
        pready = (k >= nwaits);
        prdata = $urandom;
        if (pready && !wr) rd_exp = prdata;
        @(posedge hclk); @(negedge hclk);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, err);
      chk("rsp_rdata", rsp_rdata, rd_exp);
      chk("rsp_psel", psel, 0);
      chk("rsp_penable", penable, 0);
      chk("rsp_paddr_hold", paddr, addr);
      chk("rsp_req_ready", req_ready, 1);
      $display("txn apb addr=%08h wr=%0d waits=%0d err=%0d rdata=%08h",
               addr, wr, nwaits, err, rsp_rdata);
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;
      gap_exp = hold ? acc + 2 : -1;
    end
    if (!hold) begin
      req_valid = 1'b0;
      @(posedge hclk); @(negedge hclk);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_err", rsp_err, 0);
      chk("idle_rsp_rdata", rsp_rdata, 0);
      chk("idle_psel", psel, 0);
      chk("idle_penable", penable, 0);
      chk("idle_paddr", paddr, last_paddr);
      chk("idle_pwrite", pwrite, last_pwrite);
      chk("idle_pwdata", pwdata, last_pwdata);
    end
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    bit          h;

    // Reset state
    repeat (2) @(negedge hclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    hresetn = 1'b1;
    @(negedge hclk);

    // Write, zero waits, slot 1
    run_req(1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 0, 1'b0);
    // Read, 3 waits (one short of the timeout: completion must win), slot 2
    run_req(1'b0, 32'h8800_0004, 32'h0, 3, 1'b0);
    // Timeout on a read to slot 0
    run_req(1'b0, 32'h8000_0000, 32'h0, 6, 1'b0);
    // Decode errors back-to-back
    run_req(1'b1, 32'h8C00_0000, 32'h1234_5678, 0, 1'b1);
    run_req(1'b0, 32'h7FFF_FFFC, 32'h0, 0, 1'b0);
    // Back-to-back writes
    run_req(1'b1, 32'h8000_0000, 32'hA5A5_0001, 0, 1'b1);
    run_req(1'b1, 32'h8000_0004, 32'hA5A5_0002, 0, 1'b0);

    // Reset in the middle of ACCESS wait states
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8800_0008; req_wdata = 32'h0;
    @(posedge hclk); @(negedge hclk);
    req_valid = 1'b0; pready = 1'b0;
    @(posedge hclk); @(negedge hclk);
    @(posedge hclk); @(negedge hclk);
    chk("prerst_penable", penable, 1);
    #2 hresetn = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_paddr", paddr, 0);
    $display("txn reset_abort addr=88000008");
    @(negedge hclk);
    pready = 1'b1;
    hresetn = 1'b1;
    @(posedge hclk); @(negedge hclk);
    chk("postrst_rsp_valid", rsp_valid, 0);
    chk("postrst_psel", psel, 0);
    last_paddr = 32'd0; last_pwrite = 1'b0; last_pwdata = 32'd0; gap_exp = -1;
    run_req(1'b0, 32'h8400_0000, 32'h0, 1, 1'b0);

    // Randomized traffic across all slots, out-of-window and below-base
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      case (r)
        0, 1, 2: a = BASE + 32'(r) * SLOT_SIZE + ($urandom_range(0, 32'h03FF_FFFF) & 32'hFFFF_FFFC);
        3:       a = BASE + 32'($urandom_range(3, 31)) * SLOT_SIZE + ($urandom & 32'h03FF_FFFC);
        default: a = $urandom_range(0, 32'h7FFF_FFFF);
      endcase
      h = (i != 39) && ($urandom_range(0, 1) == 1);
      run_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 6), h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB initiator for the bridge. Accepts single read/write requests on a simple valid/ready request port and decodes the address to one of three peripheral selects.
- Runs the APB SETUP→ACCESS sequence with PREADY wait-state support and a wait-state timeout.
- Returns one response per request: read data plus an error flag.
- Drives the same psel/penable/pwrite/paddr/pwdata bundle the slave-side APB interface consumes, and samples prdata from it.

Parameters:
- TIMEOUT, 16, max consecutive ACCESS cycles with pready=0 before abort. 0 disables the timeout. Legal range 0..255.
- BASE_ADDR, 32'h8000_0000, base of the peripheral window.
- SLOT_BITS, 26, log2 of each peripheral slot size (64 MB).

Ports:
- hclk  in  1  clock, rising edge
- hresetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode error or timeout; qualified by rsp_valid
- psel  out  3  one-hot peripheral select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  32  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  slave ready; tie high for zero-wait slaves

Behaviour:
- Clock and reset: one clock, hclk. Reset hresetn is asynchronous, active-low.
  - Reset values: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
  - Reset asserted mid-transfer aborts immediately. No response is issued for the aborted request.
- Registers: all outputs except req_ready are registered. req_ready = (state==IDLE), combinational.
- Decode: idx = (req_addr - BASE_ADDR) >> SLOT_BITS.
  - idx 0,1,2 → psel 3'b001, 3'b010, 3'b100.
  - Address below BASE_ADDR, or idx≥3 → decode error.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - On handshake with a valid decode: latch paddr=req_addr, pwrite=req_write, pwdata=req_wdata (pwdata=0 for reads); set psel; go to SETUP.
  - On handshake with a decode error: stay IDLE, no APB activity. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - A new request may be accepted in that same response cycle.
- SETUP: psel asserted, penable=0. Unconditionally go to ACCESS and set penable=1. Clear the wait counter.
- ACCESS: psel, penable, paddr, pwrite and pwdata held stable.
  - If pready=1: complete. psel=0, penable=0, go to IDLE. Next cycle rsp_valid=1, rsp_err=0, rsp_rdata = prdata sampled at the completing edge for reads, 0 for writes.
  - If pready=0 and TIMEOUT≠0: increment the wait counter. When it reaches TIMEOUT, abort: psel=0, penable=0, go to IDLE. Response has rsp_err=1, rsp_rdata=0.
  - A pready arriving on the same edge as the timeout wins (normal completion).
- Idle hold: paddr, pwrite and pwdata retain their last values after a transfer (no toggling). Only psel and penable return to 0.
- Latency: acceptance at edge N; SETUP during cycle N+1; ACCESS during N+2; with zero wait states rsp_valid is high in cycle N+3. Each wait state adds one cycle.
- Throughput: minimum 3 cycles per APB transfer. req_ready is low in SETUP and ACCESS; req_valid may stay high and is accepted on return to IDLE.
- rsp_valid: single-cycle pulse, with no back-pressure on the response. rsp_err and rsp_rdata are valid only while rsp_valid=1 and are cleared to 0 when it is low.
- Ignored signals: prdata and pready are ignored outside ACCESS.

Test Plan:
- Write, 0 waits: req_addr=0x8400_0010, wdata=0xDEAD_BEEF, pready=1 → SETUP with psel=010, penable=0, pwrite=1, then ACCESS with penable=1; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read, 3 waits: req_addr=0x8800_0004; pready low 3 ACCESS cycles, then high with prdata=0x0000_00A5 → ACCESS lasts 4 cycles with paddr/psel=100 stable; rsp_rdata=0xA5 at N+6.
- Timeout: TIMEOUT=4, read to 0x8000_0000, pready held 0 → penable drops after 4 ACCESS cycles; rsp_valid with rsp_err=1, rsp_rdata=0; req_ready high next cycle.
- Decode error: req_addr=0x8C00_0000, then 0x7FFF_FFFC → no psel activity; each gets rsp_valid with rsp_err=1 one cycle after acceptance; requests are accepted back-to-back.
- Back-to-back: req_valid held high with two writes to 0x8000_0000 and 0x8000_0004, pready=1 → second accepted on the cycle after the first completes; 3-cycle spacing between psel assertions; two responses.
- Reset mid-ACCESS: drop hresetn during wait states → psel, penable and rsp_valid are 0 immediately, not waiting for the next clock edge; no response for the aborted request; after release, a read to 0x8400_0000 completes normally.
